// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner_if
//  Description : Bundle between the 4x4 keypad scanner and its surroundings:
//                row sense / column drive toward the keypad matrix, and the
//                digit / digitValid / keyHeld result toward the lock.
//                master = scanner side, slave = keypad + consumer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface keypad_scanner_if;
  logic [3:0] rowIn;       // keypad rows, active-low, asynchronous to CLK
  logic [3:0] colOut;      // column drive, one-cold active-low
  logic [3:0] digit;       // code of last accepted key
  logic       digitValid;  // one-cycle strobe per accepted code
  logic       keyHeld;     // accepted key still down / release being debounced

  modport master (
    input  rowIn,
    output colOut,
    output digit,
    output digitValid,
    output keyHeld
  );

  modport slave (
    output rowIn,
    input  colOut,
    input  digit,
    input  digitValid,
    input  keyHeld
  );
endinterface
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 active-low matrix keypad scanner. Rotates a single low
//                column, synchronises the rows, debounces press and release,
//                and emits one key code per press on digit with a one-cycle
//                digitValid strobe.
//                Optional feature macro: KEYPAD_REPEAT_EN adds auto-repeat
//                strobes while the accepted key stays down.
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV      = 100,
  parameter int DEBOUNCE_CNT  = 1000,
  parameter int REPEAT_DELAY  = 50000,
  parameter int REPEAT_PERIOD = 10000
) (
  input  wire logic         CLK,
  input  wire logic         RST,
  keypad_scanner_if.master  kp
);

  // Counter widths follow their largest terminal value.
  localparam int DIV_W = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
  localparam int DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] c_deb_last = DEB_W'(DEBOUNCE_CNT - 1);
  localparam logic [3:0]       c_col0     = 4'b1110;
  localparam logic [3:0]       c_rows_idle = 4'hF;

  // Parameter domain guard: unsupported values stop elaboration.
  if ((SCAN_DIV < 4) || (DEBOUNCE_CNT < 2) || (REPEAT_DELAY < 2) || (REPEAT_PERIOD < 1)) begin : g_param_check
    $error("keypad_scanner: parameter value out of supported range");
  end

  typedef enum logic [1:0] {
    S_SCAN  = 2'd0,
    S_PRESS = 2'd1,
    S_HELD  = 2'd2
  } state_t;

  // True when exactly one of the four active-low bits is low.
  function automatic logic is_one_cold(input logic [3:0] v);
    logic r;
    r = (v == 4'b1110) || (v == 4'b1101) || (v == 4'b1011) || (v == 4'b0111);
    return r;
  endfunction

  // Position of the low bit in a one-cold vector.
  function automatic logic [1:0] cold_index(input logic [3:0] v);
    logic [1:0] r;
    case (v)
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // Keypad legend: row 3 carries '*'(14), '0', '#'(15), 'D'(13).
  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    case ({r, c})
      4'h0: k = 4'd1;   4'h1: k = 4'd2;   4'h2: k = 4'd3;   4'h3: k = 4'd10;
      4'h4: k = 4'd4;   4'h5: k = 4'd5;   4'h6: k = 4'd6;   4'h7: k = 4'd11;
      4'h8: k = 4'd7;   4'h9: k = 4'd8;   4'hA: k = 4'd9;   4'hB: k = 4'd12;
      4'hC: k = 4'd14;  4'hD: k = 4'd0;   4'hE: k = 4'd15;  default: k = 4'd13;
    endcase
    return k;
  endfunction

  state_t           state_q;
  logic [3:0]       sync1_q;
  logic [3:0]       rowS_q;
  logic [DIV_W-1:0] divCnt_q;
  logic [DEB_W-1:0] debCnt_q;
  logic [3:0]       colOut_q;
  logic [3:0]       rowPat_q;
  logic [3:0]       digit_q;
  logic             digitValid_q;
  logic             keyHeld_q;

  logic [3:0]       keyCode_d;
  logic [3:0]       colRot_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] c_dly_last = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] c_per_last = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] repCnt_q;
  logic             repPhase_q;   // 0: waiting initial delay, 1: periodic repeats
`endif

  // Code for the latched row against the frozen column, and the next column.
  always_comb begin
    keyCode_d = keymap(cold_index(rowPat_q), cold_index(colOut_q));
    colRot_d  = {colOut_q[2:0], colOut_q[3]};
  end

  // Row synchroniser plus scan / debounce state machine with registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_SCAN;
      sync1_q      <= 4'hF;
      rowS_q       <= 4'hF;
      divCnt_q     <= '0;
      debCnt_q     <= '0;
      colOut_q     <= c_col0;
      rowPat_q     <= 4'hF;
      digit_q      <= 4'd0;
      digitValid_q <= 1'b0;
      keyHeld_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      repCnt_q     <= '0;
      repPhase_q   <= 1'b0;
`endif
    end else begin
      sync1_q      <= kp.rowIn;
      rowS_q       <= sync1_q;
      digitValid_q <= 1'b0;

      case (state_q)
        S_SCAN: begin
          if (divCnt_q == c_div_last) begin
            divCnt_q <= '0;
            if (is_one_cold(rowS_q)) begin
              // Single key seen on this column: freeze column and debounce it.
              rowPat_q <= rowS_q;
              debCnt_q <= '0;
              state_q  <= S_PRESS;
            end else begin
              // Nothing, or an ambiguous multi-key pattern: keep scanning.
              colOut_q <= colRot_d;
            end
          end else begin
            divCnt_q <= divCnt_q + 1'b1;
          end
        end

        S_PRESS: begin
          if (rowS_q == rowPat_q) begin
            if (debCnt_q == c_deb_last) begin
              digit_q      <= keyCode_d;
              digitValid_q <= 1'b1;
              keyHeld_q    <= 1'b1;
              debCnt_q     <= '0;
              state_q      <= S_HELD;
`ifdef KEYPAD_REPEAT_EN
              repCnt_q     <= '0;
              repPhase_q   <= 1'b0;
`endif
            end else begin
              debCnt_q <= debCnt_q + 1'b1;
            end
          end else begin
            // Bounce: resume scanning on the same column from a fresh dwell.
            debCnt_q <= '0;
            divCnt_q <= '0;
            state_q  <= S_SCAN;
          end
        end

        S_HELD: begin
          if (rowS_q == c_rows_idle) begin
            if (debCnt_q == c_deb_last) begin
              keyHeld_q <= 1'b0;
              debCnt_q  <= '0;
              divCnt_q  <= '0;
              colOut_q  <= c_col0;
              state_q   <= S_SCAN;
            end else begin
              debCnt_q <= debCnt_q + 1'b1;
            end
          end else begin
            // Any low row (original key or an extra one) restarts release debounce.
            debCnt_q <= '0;
          end
`ifdef KEYPAD_REPEAT_EN
          if (rowS_q == rowPat_q) begin
            if (repCnt_q == (repPhase_q ? c_per_last : c_dly_last)) begin
              digitValid_q <= 1'b1;
              repCnt_q     <= '0;
              repPhase_q   <= 1'b1;
            end else begin
              repCnt_q <= repCnt_q + 1'b1;
            end
          end else begin
            repCnt_q   <= '0;
            repPhase_q <= 1'b0;
          end
`endif
        end

        default: begin
          // Illegal encoding: recover to a clean scan from column 0.
          state_q   <= S_SCAN;
          divCnt_q  <= '0;
          debCnt_q  <= '0;
          keyHeld_q <= 1'b0;
          colOut_q  <= c_col0;
        end
      endcase
    end
  end

  assign kp.colOut     = colOut_q;
  assign kp.digit      = digit_q;
  assign kp.digitValid = digitValid_q;
  assign kp.keyHeld    = keyHeld_q;

endmodule
`default_nettype wire
